mem_arbiter: RTL and testbench

//  Shares the single line-wide main-memory port between the instruction cache (read-only) and the data cache (read/write).

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_rr_pick2.sv | 25 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizing for the I/D-cache main-memory arbiter.
// The top-level parameters default to these values.
package mem_arbiter_pkg;

    localparam int DEF_WORD_SIZE  = 16;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_LATENCY    = 4;
    localparam int DEF_CNT_W      = 3;
    localparam int DBG_W          = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    function automatic grant_t other_port(input grant_t g);
        return (g == GRANT_I) ? GRANT_D : GRANT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a conflict the port that
// did not win the previous conflict is chosen.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  grant_t last_grant,
    output grant_t grant,
    output logic   conflict
);

    always_comb begin
        // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
        grant    = GRANT_I;
        conflict = 1'b0;
        if (req_i && req_d) begin
            conflict = 1'b1;
            grant    = other_port(last_grant);
        end else if (req_d) begin
            grant = GRANT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache:
// IDLE -> BUSY (LATENCY cycles of strobe) -> DONE (one-cycle done pulse).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int  WORD_SIZE  = DEF_WORD_SIZE,
    parameter int  LINE_WORDS = DEF_LINE_WORDS,
    parameter int  LATENCY    = DEF_LATENCY,
    parameter int  CNT_W      = DEF_CNT_W,
    localparam int LINE_W     = WORD_SIZE * LINE_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req_read,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [LINE_W-1:0]    i_rdata,
    output logic                 i_done,
    input  logic                 d_req_read,
    input  logic                 d_req_write,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [LINE_W-1:0]    d_wdata,
    output logic [LINE_W-1:0]    d_rdata,
    output logic                 d_done,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [LINE_W-1:0]    mem_wdata,
    input  logic [LINE_W-1:0]    mem_rdata,
    output logic [DBG_W-1:0]     num_grant_i,
    output logic [DBG_W-1:0]     num_grant_d,
    output logic [DBG_W-1:0]     num_conflict
);

    localparam logic [WORD_SIZE-1:0] OFF_MASK = WORD_SIZE'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(LATENCY - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    grant_t           winner;
    grant_t           last_grant;
    grant_t           grant;
    logic             conflict;
    logic             d_any;

    assign d_any = d_req_read | d_req_write;

    rr_pick2 u_pick (
        .req_i      (i_req_read),
        .req_d      (d_any),
        .last_grant (last_grant),
        .grant      (grant),
        .conflict   (conflict)
    );

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            cnt          <= '0;
            winner       <= GRANT_I;
            last_grant   <= GRANT_I;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            i_done       <= 1'b0;
            d_done       <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            num_grant_i  <= '0;
            num_grant_d  <= '0;
            num_conflict <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (i_req_read || d_any) begin
                        state  <= ARB_BUSY;
                        cnt    <= '0;
                        winner <= grant;
                        if (grant == GRANT_I) begin
                            mem_read    <= 1'b1;
                            mem_addr    <= i_addr & ~OFF_MASK;
                            mem_wdata   <= '0;
                            num_grant_i <= num_grant_i + DBG_W'(1);
                        end else begin
                            // A simultaneous read+write request is served as the write alone.
                            mem_read    <= ~d_req_write;
                            mem_write   <= d_req_write;
                            mem_addr    <= d_addr & ~OFF_MASK;
                            mem_wdata   <= d_wdata;
                            num_grant_d <= num_grant_d + DBG_W'(1);
                        end
                        if (conflict) begin
                            num_conflict <= num_conflict + DBG_W'(1);
                            last_grant   <= grant;
                        end
                    end
                end
                ARB_BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        if (mem_read) begin
                            if (winner == GRANT_I) i_rdata <= mem_rdata;
                            else                   d_rdata <= mem_rdata;
                        end
                        i_done    <= (winner == GRANT_I);
                        d_done    <= (winner == GRANT_D);
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        state     <= ARB_DONE;
                    end
                end
                ARB_DONE: state <= ARB_IDLE;
                default:  state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-timeline model.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_read;
    logic [15:0] i_addr;
    logic [63:0] i_rdata;
    logic        i_done;
    logic        d_req_read;
    logic        d_req_write;
    logic [15:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_done;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic [15:0] num_grant_i;
    logic [15:0] num_grant_d;
    logic [15:0] num_conflict;

    mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_read   (i_req_read),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_done       (i_done),
        .d_req_read   (d_req_read),
        .d_req_write  (d_req_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_done       (d_done),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .num_grant_i  (num_grant_i),
        .num_grant_d  (num_grant_d),
        .num_conflict (num_conflict)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Memory contents: unwritten lines read back as a pattern derived from the address.
    logic [63:0] mem [logic [15:0]];

    function automatic logic [63:0] default_line(input logic [15:0] a);
        return {a, ~a, a ^ 16'hA5A5, a + 16'h1};
    endfunction

    function automatic logic [63:0] mem_lookup(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return default_line(a);
    endfunction

    // Timeline model: a transaction granted in idle cycle s strobes in s+1..s+LAT,
    // pulses done in s+LAT+1, and the arbiter is idle again from s+LAT+2.
    bit          m_act = 1'b0;
    bit          m_port_d;
    bit          m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_wdata;
    int          m_start;
    bit          m_last_d = 1'b0;
    logic [63:0] e_irdata = '0;
    logic [63:0] e_drdata = '0;
    logic [15:0] e_gi = '0;
    logic [15:0] e_gd = '0;
    logic [15:0] e_cf = '0;
    int          rd_run = 0;
    int          wr_run = 0;
    bit          in_strobe, in_done, was_act, req_i_now, req_d_now;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_on) begin
            in_strobe = m_act && (cyc > m_start) && (cyc <= m_start + LAT);
            in_done   = m_act && (cyc == m_start + LAT + 1);
            check("mem_read",     64'(mem_read),     64'(in_strobe && !m_wr));
            check("mem_write",    64'(mem_write),    64'(in_strobe && m_wr));
            check("mem_addr",     64'(mem_addr),     in_strobe ? 64'(m_addr & 16'hFFFC) : 64'd0);
            check("mem_wdata",    mem_wdata,         in_strobe ? m_wdata : 64'd0);
            check("i_done",       64'(i_done),       64'(in_done && !m_port_d));
            check("d_done",       64'(d_done),       64'(in_done && m_port_d));
            check("i_rdata",      i_rdata,           e_irdata);
            check("d_rdata",      d_rdata,           e_drdata);
            check("num_grant_i",  64'(num_grant_i),  64'(e_gi));
            check("num_grant_d",  64'(num_grant_d),  64'(e_gd));
            check("num_conflict", 64'(num_conflict), 64'(e_cf));

            // Expected read data is whatever memory holds when the last strobe cycle arrives.
            if (m_act && !m_wr && cyc == m_start + LAT) begin
                if (m_port_d) e_drdata = mem_lookup(m_addr & 16'hFFFC);
                else          e_irdata = mem_lookup(m_addr & 16'hFFFC);
            end

            // Memory responds to the DUT's strobes: valid data only on the LAT-th strobe cycle.
            rd_run = mem_read  ? rd_run + 1 : 0;
            wr_run = mem_write ? wr_run + 1 : 0;
            if (mem_read && rd_run == LAT) mem_rdata = mem_lookup(mem_addr);
            else                           mem_rdata = {$urandom, $urandom};
            if (mem_write && wr_run == LAT) mem[mem_addr] = mem_wdata;

            was_act = m_act;
            if (in_done) m_act = 1'b0;
            req_i_now = i_req_read;
            req_d_now = d_req_read || d_req_write;
            if (reset) begin
                m_act    = 1'b0;
                m_last_d = 1'b0;
                e_gi     = '0;
                e_gd     = '0;
                e_cf     = '0;
                e_irdata = '0;
                e_drdata = '0;
            end else if (!was_act && (req_i_now || req_d_now)) begin
                if (req_i_now && req_d_now) begin
                    m_port_d = !m_last_d;
                    m_last_d = m_port_d;
                    e_cf     = e_cf + 16'd1;
                end else begin
                    m_port_d = req_d_now;
                end
                if (m_port_d) begin
                    e_gd    = e_gd + 16'd1;
                    m_wr    = d_req_write;
                    m_addr  = d_addr;
                    m_wdata = d_wdata;
                end else begin
                    e_gi    = e_gi + 16'd1;
                    m_wr    = 1'b0;
                    m_addr  = i_addr;
                    m_wdata = '0;
                end
                m_start = cyc;
                m_act   = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_req_read  = 1'b0;
        d_req_read  = 1'b0;
        d_req_write = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Observation window for directed scenarios; requesters drop at done unless held.
    int          n_rd, n_wr, n_id, n_dd, first_id, first_dd;
    logic [15:0] strobe_addr;
    logic [63:0] strobe_wdata;
    logic [3:0]  done_seq;

    task automatic watch(input int n, input bit hold);
        n_rd = 0; n_wr = 0; n_id = 0; n_dd = 0; first_id = -1; first_dd = -1;
        done_seq = '0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (mem_read)  begin n_rd++; strobe_addr = mem_addr; end
            if (mem_write) begin n_wr++; strobe_addr = mem_addr; strobe_wdata = mem_wdata; end
            if (i_done) begin
                n_id++;
                if (first_id < 0) first_id = k;
                done_seq = {done_seq[2:0], 1'b0};
                if (!hold) i_req_read = 1'b0;
            end
            if (d_done) begin
                n_dd++;
                if (first_dd < 0) first_dd = k;
                done_seq = {done_seq[2:0], 1'b1};
                if (!hold) begin d_req_read = 1'b0; d_req_write = 1'b0; end
            end
        end
    endtask

    int i_wait, d_wait, op;

    task automatic new_d_req();
        op          = int'($urandom_range(2));
        d_req_read  = (op != 1);
        d_req_write = (op != 0);
        d_addr      = 16'($urandom);
        d_wdata     = {$urandom, $urandom};
        d_wait      = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, limit 1000000 time units");
        $fatal(1);
    end

    initial begin
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        i_req_read = 1'b0; d_req_read = 1'b0; d_req_write = 1'b0;
        reset = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        reset = 1'b0;

        check("rst_mem_read",  64'(mem_read), 64'd0);
        check("rst_mem_addr",  64'(mem_addr), 64'd0);
        check("rst_i_rdata",   i_rdata, 64'd0);
        check("rst_d_rdata",   d_rdata, 64'd0);
        check("rst_counters",  64'({num_grant_i, num_grant_d, num_conflict}), 64'd0);

        // I-cache read alone
        i_req_read = 1'b1; i_addr = 16'h0105;
        watch(8, 1'b0);
        check("t1_strobes",  64'(n_rd), 64'd4);
        check("t1_no_write", 64'(n_wr), 64'd0);
        check("t1_done_at",  64'(first_id), 64'd5);
        check("t1_no_ddone", 64'(n_dd), 64'd0);
        check("t1_addr",     64'(strobe_addr), 64'h0104);
        check("t1_rdata",    i_rdata, 64'h0104_FEFB_A4A1_0105);

        // D-cache write
        d_req_write = 1'b1; d_addr = 16'h0203; d_wdata = 64'h1111_2222_3333_4444;
        watch(8, 1'b0);
        check("t2_strobes", 64'(n_wr), 64'd4);
        check("t2_no_read", 64'(n_rd), 64'd0);
        check("t2_done_at", 64'(first_dd), 64'd5);
        check("t2_addr",    64'(strobe_addr), 64'h0200);
        check("t2_wdata",   strobe_wdata, 64'h1111_2222_3333_4444);
        check("t2_d_rdata", d_rdata, 64'd0);

        // Simultaneous reads after reset: D first, I six cycles later
        do_reset();
        i_req_read = 1'b1; i_addr = 16'h0301;
        d_req_read = 1'b1; d_addr = 16'h0202;
        watch(12, 1'b0);
        check("t3_d_first",   64'(first_dd), 64'd5);
        check("t3_i_gap",     64'(first_id - first_dd), 64'd6);
        check("t3_conflicts", 64'(num_conflict), 64'd1);
        check("t3_d_rdata",   d_rdata, 64'h1111_2222_3333_4444);
        check("t3_i_rdata",   i_rdata, 64'h0300_FCFF_A6A5_0301);

        // Both held continuously for four transactions
        do_reset();
        i_req_read = 1'b1; d_req_read = 1'b1;
        watch(23, 1'b1);
        i_req_read = 1'b0; d_req_read = 1'b0;
        tick();
        check("t4_order",     64'(done_seq), 64'(4'b1010));
        check("t4_grant_i",   64'(num_grant_i), 64'd2);
        check("t4_grant_d",   64'(num_grant_d), 64'd2);
        check("t4_conflicts", 64'(num_conflict), 64'd4);

        // Reset in the second BUSY cycle, then a fresh D read
        d_req_read = 1'b1; d_addr = 16'h0041;
        tick();
        tick();
        check("t5_mid_busy", 64'({mem_read, num_grant_d}), 64'({1'b1, 16'd3}));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_strobes_off", 64'({mem_read, mem_write, d_done}), 64'd0);
        check("t5_counters",    64'({num_grant_i, num_grant_d, num_conflict}), 64'd0);
        watch(8, 1'b0);
        check("t5_done_at", 64'(first_dd), 64'd5);
        check("t5_one_done", 64'(n_dd), 64'd1);
        check("t5_rdata",   d_rdata, 64'h0040_FFBF_A5E5_0041);

        // Read and write together: write only, one done, rdata untouched
        d_req_read = 1'b1; d_req_write = 1'b1; d_addr = 16'h0208; d_wdata = 64'hDEAD_BEEF_0123_4567;
        watch(8, 1'b0);
        check("t6_writes",   64'(n_wr), 64'd4);
        check("t6_no_read",  64'(n_rd), 64'd0);
        check("t6_one_done", 64'(n_dd), 64'd1);
        check("t6_wdata",    strobe_wdata, 64'hDEAD_BEEF_0123_4567);
        check("t6_d_rdata",  d_rdata, 64'h0040_FFBF_A5E5_0041);

        // Randomized traffic with occasional resets
        i_wait = 0; d_wait = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset = ($urandom_range(299) == 0);
            if (i_req_read) begin
                if (i_done) begin
                    check("i_wait_bound", 64'(i_wait <= 60), 64'd1);
                    i_req_read = ($urandom_range(3) == 0);
                    i_addr     = 16'($urandom);
                    i_wait     = 0;
                end else i_wait++;
            end else if ($urandom_range(2) == 0) begin
                i_req_read = 1'b1; i_addr = 16'($urandom); i_wait = 0;
            end
            if (d_req_read || d_req_write) begin
                if (d_done) begin
                    check("d_wait_bound", 64'(d_wait <= 60), 64'd1);
                    if ($urandom_range(3) == 0) new_d_req();
                    else begin d_req_read = 1'b0; d_req_write = 1'b0; end
                end else d_wait++;
            end else if ($urandom_range(2) == 0) begin
                new_d_req();
            end
        end

        reset = 1'b0;
        for (int n = 0; n < 60 && (i_req_read || d_req_read || d_req_write); n++) begin
            tick();
            if (i_done) i_req_read = 1'b0;
            if (d_done) begin d_req_read = 1'b0; d_req_write = 1'b0; end
        end
        check("drain_idle", 64'({i_req_read, d_req_read, d_req_write}), 64'd0);
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
